// File: rtl/vid_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vid_pkg
//  Description : Shared video-path helpers: constant-function ceil-div and
//                clog2, default NTSC/VGA line constants, and the packed FIFO
//                word layout {eol, chroma_sel, x, data} for the default
//                16-bit / 10-bit configuration.
//  Revision    : 1.0  initial release
// ============================================================================
package vid_pkg;

    localparam int unsigned C_NTSC_WIDTH  = 720;
    localparam int unsigned C_VGA_WIDTH   = 640;
    localparam int unsigned C_SKIP_PERIOD = 9;
    localparam int unsigned C_DATA_W      = 16;
    localparam int unsigned C_X_W         = 10;
    localparam int unsigned C_FIFO_DEPTH  = 64;

    function automatic int unsigned ceil_div(input int unsigned a, input int unsigned b);
        return (a + b - 1) / b;
    endfunction

    // Smallest r with 2**r >= v (0 for v <= 1).
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((32'd1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    // Word layout for the default build; the decimator declares an
    // equivalently ordered word sized by its own parameters.
    typedef struct packed {
        logic                eol;
        logic                chroma_sel;
        logic [C_X_W-1:0]    x;
        logic [C_DATA_W-1:0] data;
    } fifo_word_t;

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo
//  Description : Single-clock show-ahead FIFO with occupancy output.
//                A push into a full FIFO is accepted only when a pop happens
//                in the same cycle; otherwise it is reported on wr_drop.
//                rd_data reads zero while empty.
//  Ports       : clk, aresetn (sync, active-low), clear (sync flush),
//                wr_en/wr_data, rd_en/rd_data/rd_valid, level, wr_drop
//  Revision    : 1.0  initial release
// ============================================================================
module sync_fifo
    import vid_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    aresetn,
    input  logic                    clear,
    input  logic                    wr_en,
    input  logic [WIDTH-1:0]        wr_data,
    input  logic                    rd_en,
    output logic [WIDTH-1:0]        rd_data,
    output logic                    rd_valid,
    output logic [clog2(DEPTH):0]   level,
    output logic                    wr_drop
);

    localparam int AW    = clog2(DEPTH);
    localparam int LVL_W = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [LVL_W-1:0] r_level;

    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_push;

    assign w_empty = (r_level == '0);
    assign w_full  = (r_level == LVL_W'(DEPTH));
    assign w_pop   = rd_en & ~w_empty;
    // Full plus simultaneous pop frees a slot in the same edge.
    assign w_push  = wr_en & (~w_full | w_pop);

    always_ff @(posedge clk) begin
        if (!aresetn || clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            unique case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    // Storage needs no reset: the pointers and level decide what is visible.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= wr_data;
    end

    assign rd_data  = w_empty ? '0 : r_mem[r_rd_ptr];
    assign rd_valid = ~w_empty;
    assign level    = r_level;
    assign wr_drop  = wr_en & w_full & ~w_pop;

endmodule
`default_nettype wire

// File: rtl/line_decimator_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : line_decimator_fifo
//  Description : Horizontal decimator plus elastic buffer. Drops every
//                sample whose in-line index x is a multiple of SKIP_PERIOD,
//                tags kept samples with chroma phase, output index and
//                end-of-line, and queues them for a valid/ready consumer.
//  Ports       : clk, aresetn (sync, active-low), clear (sync flush)
//                in_data/in_valid/in_sol      non-stallable input stream
//                out_data/out_valid/out_ready show-ahead output handshake
//                out_eol/out_chroma_sel/out_x head-sample tags
//                fifo_level, overflow (sticky)
//                drop_count (only with DECIM_DROP_CNT_EN defined)
//  Options     : DECIM_DROP_CNT_EN adds a 16-bit saturating count of kept
//                samples lost to a full FIFO.
//  Revision    : 1.0  initial release
// ============================================================================
module line_decimator_fifo
    import vid_pkg::*;
#(
    parameter int DATA_W      = C_DATA_W,
    parameter int IN_WIDTH    = C_NTSC_WIDTH,
    parameter int SKIP_PERIOD = C_SKIP_PERIOD,
    parameter int FIFO_DEPTH  = C_FIFO_DEPTH,
    parameter int X_W         = C_X_W
) (
    input  logic                          clk,
    input  logic                          aresetn,
    input  logic                          clear,
    input  logic [DATA_W-1:0]             in_data,
    input  logic                          in_valid,
    input  logic                          in_sol,
    output logic [DATA_W-1:0]             out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          out_eol,
    output logic                          out_chroma_sel,
    output logic [X_W-1:0]                out_x,
    output logic [clog2(FIFO_DEPTH):0]    fifo_level,
    output logic                          overflow
`ifdef DECIM_DROP_CNT_EN
    ,
    output logic [15:0]                   drop_count
`endif
);

    localparam int OUT_WIDTH = IN_WIDTH - int'(ceil_div(IN_WIDTH, SKIP_PERIOD));
    localparam int PH_W      = clog2(SKIP_PERIOD);
    // One extra bit so the "past end of line" value IN_WIDTH always fits.
    localparam int XC_W      = X_W + 1;

    typedef struct packed {
        logic              eol;
        logic              chroma_sel;
        logic [X_W-1:0]    x;
        logic [DATA_W-1:0] data;
    } word_t;

    logic [XC_W-1:0] r_x;
    logic [PH_W-1:0] r_phase;
    logic [X_W-1:0]  r_quot;
    logic [X_W-1:0]  r_ox;
    logic            r_stg_vld;
    word_t           r_stg_word;
    logic            r_overflow;

    logic [XC_W-1:0] w_x;
    logic [PH_W-1:0] w_phase;
    logic [X_W-1:0]  w_quot;
    logic [X_W-1:0]  w_ox;
    logic            w_in_line;
    logic            w_phase_wrap;
    logic            w_keep;
    word_t           w_head;
    logic            w_drop;

    // Counters describe the sample arriving now; in_sol overrides them.
    always_comb begin
        w_x          = in_sol ? '0 : r_x;
        w_phase      = in_sol ? '0 : r_phase;
        w_quot       = in_sol ? '0 : r_quot;
        w_ox         = in_sol ? '0 : r_ox;
        w_in_line    = (w_x < XC_W'(IN_WIDTH));
        w_phase_wrap = (w_phase == PH_W'(SKIP_PERIOD - 1));
        w_keep       = in_valid & w_in_line & (w_phase != '0);
    end

    // Input side registers the tagged sample first, so nothing on in_*
    // reaches the outputs combinationally; the FIFO write follows one edge later.
    always_ff @(posedge clk) begin
        if (!aresetn || clear) begin
            r_x        <= XC_W'(IN_WIDTH);
            r_phase    <= '0;
            r_quot     <= '0;
            r_ox       <= '0;
            r_stg_vld  <= 1'b0;
            r_stg_word <= '0;
        end else if (in_valid) begin
            r_x     <= w_in_line ? (w_x + 1'b1) : w_x;
            r_phase <= w_phase_wrap ? '0 : (w_phase + 1'b1);
            r_quot  <= w_phase_wrap ? (w_quot + 1'b1) : w_quot;
            if (w_keep && (w_ox != X_W'(OUT_WIDTH - 1))) r_ox <= w_ox + 1'b1;
            else                                         r_ox <= w_ox;
            r_stg_vld             <= w_keep;
            r_stg_word.eol        <= (w_x == XC_W'(IN_WIDTH - 1));
            r_stg_word.chroma_sel <= w_quot[0];
            r_stg_word.x          <= w_ox;
            r_stg_word.data       <= in_data;
        end else begin
            r_stg_vld <= 1'b0;
        end
    end

    sync_fifo #(
        .WIDTH (($bits(word_t))),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .aresetn  (aresetn),
        .clear    (clear),
        .wr_en    (r_stg_vld),
        .wr_data  (r_stg_word),
        .rd_en    (out_ready),
        .rd_data  (w_head),
        .rd_valid (out_valid),
        .level    (fifo_level),
        .wr_drop  (w_drop)
    );

    always_ff @(posedge clk) begin
        if (!aresetn || clear) r_overflow <= 1'b0;
        else if (w_drop)       r_overflow <= 1'b1;
    end

`ifdef DECIM_DROP_CNT_EN
    logic [15:0] r_drop_count;
    always_ff @(posedge clk) begin
        if (!aresetn || clear)                   r_drop_count <= '0;
        else if (w_drop && (r_drop_count != '1)) r_drop_count <= r_drop_count + 1'b1;
    end
    assign drop_count = r_drop_count;
`endif

    assign out_data       = w_head.data;
    assign out_eol        = w_head.eol;
    assign out_chroma_sel = w_head.chroma_sel;
    assign out_x          = w_head.x;
    assign overflow       = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_line_decimator_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_line_decimator_fifo
//  Description : Self-checking bench for line_decimator_fifo (default
//                parameters). Table-driven handshake vectors plus directed
//                sequences for full lines, overflow, full-with-pop, mid-line
//                restart, clear and reset.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_line_decimator_fifo;

    localparam int DATA_W = 16;
    localparam int X_W    = 10;
    localparam int LVL_W  = 7;

    logic              clk = 1'b0;
    logic              aresetn;
    logic              clear;
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_sol;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_eol;
    logic              out_chroma_sel;
    logic [X_W-1:0]    out_x;
    logic [LVL_W-1:0]  fifo_level;
    logic              overflow;
`ifdef DECIM_DROP_CNT_EN
    logic [15:0]       drop_count;
`endif

    always #5 clk = ~clk;

    line_decimator_fifo dut (
        .clk            (clk),
        .aresetn        (aresetn),
        .clear          (clear),
        .in_data        (in_data),
        .in_valid       (in_valid),
        .in_sol         (in_sol),
        .out_data       (out_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_eol        (out_eol),
        .out_chroma_sel (out_chroma_sel),
        .out_x          (out_x),
        .fifo_level     (fifo_level),
        .overflow       (overflow)
`ifdef DECIM_DROP_CNT_EN
        ,
        .drop_count     (drop_count)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic        v;
        logic        s;
        logic        r;
        logic [15:0] d;
        logic        ev;
        logic [15:0] ed;
        logic [9:0]  ex;
        logic [6:0]  el;
    } vec_t;

    typedef struct {
        logic [15:0] data;
        logic [9:0]  ox;
        logic        eol;
        logic        cs;
    } exp_t;

    exp_t mq[$];
    exp_t dq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input int start, input int count, input bit sol_first);
        for (int i = 0; i < count; i++) begin
            in_valid = 1'b1;
            in_sol   = sol_first && (i == 0);
            in_data  = 16'(start + i);
            tick();
        end
        in_valid = 1'b0;
        in_sol   = 1'b0;
    endtask

    // Output index of a kept sample v on an uninterrupted line.
    function automatic logic [9:0] ox_of(input int v);
        return 10'(v - v / 9 - 1);
    endfunction

    // Expected drain list: first n kept values starting at lo.
    task automatic build_dq(input int lo, input int n);
        exp_t e;
        int   v;
        v = lo;
        while (dq.size() < n) begin
            if (v % 9 != 0) begin
                e.data = 16'(v); e.ox = ox_of(v); e.eol = 1'b0; e.cs = 1'b0;
                dq.push_back(e);
            end
            v++;
        end
    endtask

    task automatic drain(input string tag, input int n);
        exp_t e;
        out_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            if (dq.size() == 0) begin
                chk({tag, "_queue_underrun"}, 32'(1), 32'(0));
            end else begin
                e = dq.pop_front();
                chk({tag, "_valid"}, 32'(out_valid), 32'(1));
                chk({tag, "_data"},  32'(out_data),  32'(e.data));
                chk({tag, "_x"},     32'(out_x),     32'(e.ox));
            end
            tick();
        end
        out_ready = 1'b0;
    endtask

    // Streams n samples (data = x) with out_ready held high and compares
    // every word leaving the FIFO with an independent line model.
    task automatic feed_line(input string tag, input int n);
        exp_t e;
        int   n_out, n_eol, ox;
        logic [15:0] first;
        n_out = 0; n_eol = 0; ox = 0; first = 16'hFFFF;
        out_ready = 1'b1;
        for (int c = 0; c < n + 6; c++) begin
            if (c < n) begin
                in_valid = 1'b1;
                in_sol   = (c == 0);
                in_data  = 16'(c);
                if (c < 720 && c % 9 != 0) begin
                    e.data = 16'(c); e.ox = 10'(ox); e.eol = (c == 719);
                    e.cs   = ((c / 9) % 2) == 1;
                    mq.push_back(e);
                    ox++;
                end
            end else begin
                in_valid = 1'b0;
                in_sol   = 1'b0;
            end
            tick();
            if (out_valid) begin
                if (n_out == 0) first = out_data;
                n_out++;
                if (out_eol) n_eol++;
                if (mq.size() == 0) begin
                    chk({tag, "_unexpected_output"}, 32'(out_data), 32'hFFFF_FFFF);
                end else begin
                    e = mq.pop_front();
                    chk({tag, "_data"}, 32'(out_data),       32'(e.data));
                    chk({tag, "_x"},    32'(out_x),          32'(e.ox));
                    chk({tag, "_eol"},  32'(out_eol),        32'(e.eol));
                    chk({tag, "_cs"},   32'(out_chroma_sel), 32'(e.cs));
                end
            end
        end
        out_ready = 1'b0;
        chk({tag, "_count"},     32'(n_out),     32'(640));
        chk({tag, "_eol_count"}, 32'(n_eol),     32'(1));
        chk({tag, "_first"},     32'(first),     32'(1));
        chk({tag, "_leftover"},  32'(mq.size()), 32'(0));
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    vec_t tbl[9];

    initial begin
        tbl[0] = '{1'b1, 1'b1, 1'b0, 16'h00A0, 1'b0, 16'h0000, 10'd0, 7'd0};
        tbl[1] = '{1'b1, 1'b0, 1'b0, 16'h00A1, 1'b0, 16'h0000, 10'd0, 7'd0};
        tbl[2] = '{1'b1, 1'b0, 1'b0, 16'h00A2, 1'b1, 16'h00A1, 10'd0, 7'd1};
        tbl[3] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h00A1, 10'd0, 7'd2};
        tbl[4] = '{1'b0, 1'b0, 1'b1, 16'h0000, 1'b1, 16'h00A2, 10'd1, 7'd1};
        tbl[5] = '{1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 16'h0000, 10'd0, 7'd0};
        tbl[6] = '{1'b1, 1'b0, 1'b1, 16'h00A3, 1'b0, 16'h0000, 10'd0, 7'd0};
        tbl[7] = '{1'b0, 1'b0, 1'b1, 16'h0000, 1'b1, 16'h00A3, 10'd2, 7'd1};
        tbl[8] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h00A3, 10'd2, 7'd1};

        aresetn = 1'b0; clear = 1'b0; in_data = '0; in_valid = 1'b0;
        in_sol = 1'b0; out_ready = 1'b0;
        tick(); tick();
        aresetn = 1'b1;

        // Reset state; samples before any in_sol are ignored.
        chk("rst_valid", 32'(out_valid),  32'(0));
        chk("rst_level", 32'(fifo_level), 32'(0));
        chk("rst_ovf",   32'(overflow),   32'(0));
        chk("rst_data",  32'(out_data),   32'(0));
        feed(5, 4, 1'b0);
        tick();
        chk("pre_sol_level", 32'(fifo_level), 32'(0));

        // Cycle-by-cycle handshake vectors.
        for (int i = 0; i < 9; i++) begin
            in_valid  = tbl[i].v;
            in_sol    = tbl[i].s;
            in_data   = tbl[i].d;
            out_ready = tbl[i].r;
            tick();
            chk($sformatf("vec%0d_valid", i), 32'(out_valid),  32'(tbl[i].ev));
            chk($sformatf("vec%0d_data", i),  32'(out_data),   32'(tbl[i].ed));
            chk($sformatf("vec%0d_x", i),     32'(out_x),      32'(tbl[i].ex));
            chk($sformatf("vec%0d_level", i), 32'(fifo_level), 32'(tbl[i].el));
        end
        in_valid = 1'b0; out_ready = 1'b0;
        do_clear();

        // Full lines: exactly IN_WIDTH samples, then a line running long.
        feed_line("line720", 720);
        feed_line("line730", 730);

        // Overflow with the consumer stalled.
        feed(0, 80, 1'b1);
        tick();
        chk("ovf_level", 32'(fifo_level), 32'(64));
        chk("ovf_flag",  32'(overflow),   32'(1));
`ifdef DECIM_DROP_CNT_EN
        chk("ovf_drop_count", 32'(drop_count), 32'(7));
`endif
        build_dq(1, 64);
        drain("ovf_drain", 64);
        chk("ovf_empty", 32'(out_valid), 32'(0));

        // Clear mid-line with 20 queued; overflow still sticky from above.
        feed(80, 23, 1'b0);
        tick();
        chk("clr_pre_level", 32'(fifo_level), 32'(20));
        chk("clr_pre_ovf",   32'(overflow),   32'(1));
        clear = 1'b1; in_valid = 1'b1; in_data = 16'h5A5A;
        tick();
        clear = 1'b0; in_valid = 1'b0;
        chk("clr_valid", 32'(out_valid),      32'(0));
        chk("clr_level", 32'(fifo_level),     32'(0));
        chk("clr_ovf",   32'(overflow),       32'(0));
        chk("clr_data",  32'(out_data),       32'(0));
        chk("clr_x",     32'(out_x),          32'(0));
        chk("clr_eol",   32'(out_eol),        32'(0));
        chk("clr_cs",    32'(out_chroma_sel), 32'(0));
`ifdef DECIM_DROP_CNT_EN
        chk("clr_drop_count", 32'(drop_count), 32'(0));
`endif
        tick();
        chk("clr_same_cycle_sample", 32'(fifo_level), 32'(0));
        feed(103, 5, 1'b0);
        tick(); tick();
        chk("clr_wait_sol", 32'(fifo_level), 32'(0));
        feed(0, 2, 1'b1);
        tick();
        chk("clr_resume_level", 32'(fifo_level), 32'(1));
        chk("clr_resume_data",  32'(out_data),   32'(1));

        // Full FIFO: simultaneous pop and write keeps the level and the flag.
        do_clear();
        feed(0, 72, 1'b1);
        tick();
        chk("full_level", 32'(fifo_level), 32'(64));
        chk("full_ovf0",  32'(overflow),   32'(0));
        feed(72, 1, 1'b0);
        feed(73, 1, 1'b0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("fullpop_level", 32'(fifo_level), 32'(64));
        chk("fullpop_ovf",   32'(overflow),   32'(0));
        build_dq(2, 63);
        build_dq(73, 64);
        drain("fullpop_drain", 64);
        chk("fullpop_empty", 32'(out_valid), 32'(0));

        // in_sol mid-line restarts indices; queued words are kept.
        do_clear();
        feed(0, 21, 1'b1);
        feed(16'h300, 1, 1'b1);
        feed(16'h301, 2, 1'b0);
        tick();
        chk("sol_level", 32'(fifo_level), 32'(20));
        build_dq(1, 18);
        dq.push_back('{16'h301, 10'd0, 1'b0, 1'b0});
        dq.push_back('{16'h302, 10'd1, 1'b0, 1'b0});
        drain("sol_drain", 20);

        // Reset mid-line behaves like clear.
        feed(0, 12, 1'b1);
        tick();
        chk("rst_mid_pre_level", 32'(fifo_level), 32'(10));
        aresetn = 1'b0;
        tick();
        aresetn = 1'b1;
        chk("rst_mid_valid", 32'(out_valid),  32'(0));
        chk("rst_mid_level", 32'(fifo_level), 32'(0));
        feed(12, 3, 1'b0);
        tick();
        chk("rst_mid_ignore", 32'(fifo_level), 32'(0));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
